// File: rtl/gray_counter_param.sv
// Parametrised up/down counter with binary and Gray views registered together.
// Both views are loaded from the same next-value, so gray_out never lags bin_out.
// Priority per edge: clr > load > en > hold. At a terminal value a count step
// either wraps modulo 2^WIDTH (WRAP_EN=1) or is blocked (WRAP_EN=0). In both
// cases wrap_evt pulses for one cycle.
module gray_counter_param #(
    parameter int               WIDTH   = 16,
    parameter bit               WRAP_EN = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             term,
    output logic             wrap_evt
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_nxt;
    logic             term_nxt;
    logic             wrap_nxt;
    logic             at_end;

    // Next-state selection; a blocked saturating step keeps the value but still flags wrap_evt
    always_comb begin
        bin_nxt  = bin_out;
        term_nxt = term;
        wrap_nxt = 1'b0;
        at_end   = dir ? (bin_out == ALL_ONES) : (bin_out == '0);
        if (clr) begin
            bin_nxt  = '0;
            term_nxt = 1'b1;
        end else if (load) begin
            bin_nxt  = load_val;
            term_nxt = dir ? (load_val == ALL_ONES) : (load_val == '0);
        end else if (en) begin
            wrap_nxt = at_end;
            if (!at_end || WRAP_EN) begin
                bin_nxt = dir ? (bin_out + ONE) : (bin_out - ONE);
            end
            term_nxt = dir ? (bin_nxt == ALL_ONES) : (bin_nxt == '0);
        end
    end

    // Register binary, Gray, terminal level and event pulse from one next value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_out  <= RST_VAL;
            gray_out <= to_gray(RST_VAL);
            term     <= (RST_VAL == '0);
            wrap_evt <= 1'b0;
        end else begin
            bin_out  <= bin_nxt;
            gray_out <= to_gray(bin_nxt);
            term     <= term_nxt;
            wrap_evt <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances share one stimulus stream
// (4-bit wrapping with reset value 5, 4-bit saturating, 16-bit wrapping) and
// are compared every cycle against an arithmetic reference model.
module tb_gray_counter_param;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;

    logic [3:0]  bin_a, gray_a, bin_s, gray_s;
    logic [15:0] bin_w, gray_w;
    logic        term_a, term_s, term_w, evt_a, evt_s, evt_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .WRAP_EN(1'b1), .RST_VAL(4'd5)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .bin_out(bin_a), .gray_out(gray_a),
        .term(term_a), .wrap_evt(evt_a));

    gray_counter_param #(.WIDTH(4), .WRAP_EN(1'b0), .RST_VAL(4'd0)) dut_s (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .bin_out(bin_s), .gray_out(gray_s),
        .term(term_s), .wrap_evt(evt_s));

    gray_counter_param #(.WIDTH(16), .WRAP_EN(1'b1), .RST_VAL(16'd0)) dut_w (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .bin_out(bin_w), .gray_out(gray_w),
        .term(term_w), .wrap_evt(evt_w));

    logic [15:0] ob [3];
    logic [15:0] og [3];
    logic        ot [3];
    logic        oe [3];
    assign ob[0] = {12'd0, bin_a};  assign og[0] = {12'd0, gray_a};
    assign ob[1] = {12'd0, bin_s};  assign og[1] = {12'd0, gray_s};
    assign ob[2] = bin_w;           assign og[2] = gray_w;
    assign ot[0] = term_a; assign ot[1] = term_s; assign ot[2] = term_w;
    assign oe[0] = evt_a;  assign oe[1] = evt_s;  assign oe[2] = evt_w;

    // Reference model state per instance
    int unsigned cw   [3] = '{4, 4, 16};
    bit          cwr  [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned crst [3] = '{5, 0, 0};
    int unsigned mv   [3];
    bit          mt   [3];
    bit          me   [3];
    bit          moved[3];
    logic [15:0] prev_g [3];
    int          wraps_w = 0;

    function automatic int unsigned maxv(input int i);
        return (32'd1 << cw[i]) - 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = crst[i];
            mt[i] = (crst[i] == 0);
            me[i] = 1'b0;
            moved[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int unsigned mx;
            mx = maxv(i);
            moved[i] = 1'b0;
            me[i] = 1'b0;
            if (clr) begin
                mv[i] = 0;
                mt[i] = 1'b1;
            end else if (load) begin
                mv[i] = load_val & mx;
                mt[i] = dir ? (mv[i] == mx) : (mv[i] == 0);
            end else if (en) begin
                if (dir) begin
                    if (mv[i] == mx) begin
                        me[i] = 1'b1;
                        if (cwr[i]) begin mv[i] = 0; moved[i] = 1'b1; end
                    end else begin
                        mv[i] = mv[i] + 1; moved[i] = 1'b1;
                    end
                    mt[i] = (mv[i] == mx);
                end else begin
                    if (mv[i] == 0) begin
                        me[i] = 1'b1;
                        if (cwr[i]) begin mv[i] = mx; moved[i] = 1'b1; end
                    end else begin
                        mv[i] = mv[i] - 1; moved[i] = 1'b1;
                    end
                    mt[i] = (mv[i] == 0);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h t=%0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] eb;
            eb = mv[i][15:0];
            chk("bin", i, ob[i], eb);
            chk("gray", i, og[i], eb ^ (eb >> 1));
            chk("term", i, {15'd0, ot[i]}, {15'd0, mt[i]});
            chk("wrap_evt", i, {15'd0, oe[i]}, {15'd0, me[i]});
            if (moved[i])
                chk("gray_hamming", i, 16'($countones(og[i] ^ prev_g[i])), 16'd1);
            prev_g[i] = og[i];
        end
        if (evt_w) wraps_w++;
    endtask

    task automatic step(input logic e, input logic d, input logic c, input logic l, input logic [15:0] lv);
        en = e; dir = d; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Count up a few, then asynchronous reset mid-cycle
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        model_edge();
        check_all();

        // Clear, then 17 up-steps across the 4-bit wrap
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 17; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

        // Load 2 and count down 5 times into the bottom
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        // Priority: clr beats load and en; then load beats en
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'd9);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'd9);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'd10);
        chk("load10_gray", 0, og[0], 16'd15);

        // Hold at 6 while toggling dir
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'd6);
        for (int k = 0; k < 10; k++) step(1'b0, k[0], 1'b0, 1'b0, 16'd0);
        chk("hold6_gray", 0, og[0], 16'd5);

        // Randomized mix of controls
        for (int k = 0; k < 600; k++) begin
            logic re, rd, rc, rl;
            rc = ($urandom_range(0, 15) == 0);
            rl = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 3) != 0);
            rd = $urandom_range(0, 1) != 0;
            step(re, rd, rc, rl, 16'($urandom));
        end

        // Long 16-bit up-count through one wrap
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        wraps_w = 0;
        for (int k = 0; k < 70000; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("wraps16", 2, 16'(wraps_w), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
